// File: rtl/mod_add_seq_if.sv
// Handshake bundle between the point-arithmetic sequencer (master) and the
// limb-serial modular adder (slave).
interface mod_add_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] A;
  logic [255:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] R;
  logic         busy;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, R, busy
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, R, busy
  );
endinterface

// File: rtl/mod_add_seq.sv
// Limb-serial modular adder R = (A + B) mod p for the secp256k1 field.
// Sum and sum-minus-p are built side by side, one LIMB_W-bit limb per cycle.
module mod_add_seq #(
  parameter int unsigned  LIMB_W  = 64,
  parameter logic [255:0] P_CONST = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F
) (
  input logic          clk,
  input logic          rst_n,
  mod_add_seq_if.slave bus
);
  localparam int unsigned N     = 256 / LIMB_W;
  localparam int unsigned CNT_W = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    SEL  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [255:0]     a_r;
  logic [255:0]     b_r;
  logic [255:0]     p_r;
  logic [255:0]     s_r;
  logic [255:0]     t_r;
  logic [255:0]     r_r;
  logic             c_r;
  logic             bw_r;
  logic [CNT_W-1:0] idx_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;
  logic [LIMB_W:0]  sum_s;
  logic [LIMB_W:0]  diff_s;

  // Operands drain LSB-first from the bottom; results fill from the top so
  // that after N limbs the lowest limb sits at bit 0.
  function automatic logic [255:0] push_limb(input logic [255:0] v, input logic [LIMB_W-1:0] limb);
    logic [255+LIMB_W:0] w;
    w = {limb, v};
    return w[255+LIMB_W:LIMB_W];
  endfunction

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.R         = r_r;

  // Current-limb add with carry and trial subtract of p with borrow
  always_comb begin
    sum_s  = {1'b0, a_r[LIMB_W-1:0]} + {1'b0, b_r[LIMB_W-1:0]} + {{LIMB_W{1'b0}}, c_r};
    diff_s = {1'b0, sum_s[LIMB_W-1:0]} - {1'b0, p_r[LIMB_W-1:0]} - {{LIMB_W{1'b0}}, bw_r};
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid && in_ready_r) state_s = ADD;
        else                            state_s = IDLE;
      end
      ADD: begin
        if (idx_r == CNT_W'(N - 1)) state_s = SEL;
        else                        state_s = ADD;
      end
      SEL: state_s = DONE;
      DONE: begin
        if (bus.out_ready && out_valid_r) state_s = IDLE;
        else                              state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Handshake outputs follow the next state so they are valid from the edge on
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
      busy_r      <= (state_s != IDLE);
    end
  end

  // Limb datapath and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= 256'd0;
      b_r   <= 256'd0;
      p_r   <= 256'd0;
      s_r   <= 256'd0;
      t_r   <= 256'd0;
      r_r   <= 256'd0;
      c_r   <= 1'b0;
      bw_r  <= 1'b0;
      idx_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            a_r   <= bus.A;
            b_r   <= bus.B;
            p_r   <= P_CONST;
            c_r   <= 1'b0;
            bw_r  <= 1'b0;
            idx_r <= {CNT_W{1'b0}};
          end
        end
        ADD: begin
          a_r   <= push_limb(a_r, {LIMB_W{1'b0}});
          b_r   <= push_limb(b_r, {LIMB_W{1'b0}});
          p_r   <= push_limb(p_r, {LIMB_W{1'b0}});
          s_r   <= push_limb(s_r, sum_s[LIMB_W-1:0]);
          t_r   <= push_limb(t_r, diff_s[LIMB_W-1:0]);
          c_r   <= sum_s[LIMB_W];
          bw_r  <= diff_s[LIMB_W];
          idx_r <= idx_r + CNT_W'(1);
        end
        // Subtract p exactly when the 257-bit sum reached p
        SEL: r_r <= (c_r | ~bw_r) ? t_r : s_r;
        DONE: r_r <= r_r;
        default: r_r <= r_r;
      endcase
    end
  end
endmodule

// File: tb/tb_mod_add_seq.sv
// Self-checking bench for mod_add_seq: directed cases on a 64-bit-limb instance,
// then randomized back-to-back traffic on 32/64/256-bit-limb instances.
module tb_mod_add_seq;
  localparam logic [255:0] P = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam int N_RAND = 2500;

  logic clk = 1'b0;
  logic rst_n;
  bit   rand_go = 1'b0;
  int   n_checks = 0;
  int   n_fails = 0;

  always #5 clk = ~clk;

  mod_add_seq_if bus_d ();
  mod_add_seq #(.LIMB_W(64)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus_d));

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] ref_add(input logic [255:0] a, input logic [255:0] b);
    logic [256:0] s;
    s = ({1'b0, a} + {1'b0, b}) % {1'b0, P};
    return s[255:0];
  endfunction

  function automatic logic [255:0] mod_sub(input logic [255:0] r, input logic [255:0] b);
    logic [256:0] d;
    d = ({1'b0, r} + {1'b0, P} - {1'b0, b}) % {1'b0, P};
    return d[255:0];
  endfunction

  function automatic logic [255:0] rand_fe();
    logic [255:0] x;
    do begin
      for (int i = 0; i < 8; i++) x[i*32 +: 32] = $urandom;
    end while (x >= P);
    case ($urandom_range(0, 15))
      0:       x = P - 256'd1;
      1:       x = 256'd0;
      default: x = x;
    endcase
    return x;
  endfunction

  task automatic start_op(input logic [255:0] a, input logic [255:0] b);
    int n;
    @(negedge clk);
    bus_d.A = a;
    bus_d.B = b;
    bus_d.in_valid = 1'b1;
    n = 0;
    while (!bus_d.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("accept_ready", {255'd0, bus_d.in_ready}, 256'd1);
    @(negedge clk);
    bus_d.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!bus_d.out_valid && lat < 50) begin
      check_val("busy_run", {255'd0, bus_d.busy}, 256'd1);
      @(negedge clk);
      lat++;
    end
    check_val("latency", 256'(lat), 256'd5);
  endtask

  task automatic finish_op(input string tag, input logic [255:0] exp);
    check_val(tag, bus_d.R, exp);
    check_val("busy_done", {255'd0, bus_d.busy}, 256'd1);
    bus_d.out_ready = 1'b1;
    @(negedge clk);
    bus_d.out_ready = 1'b0;
    check_val("ovalid_clr", {255'd0, bus_d.out_valid}, 256'd0);
    check_val("iready_back", {255'd0, bus_d.in_ready}, 256'd1);
    check_val("busy_clr", {255'd0, bus_d.busy}, 256'd0);
  endtask

  task automatic run_op(input string tag, input logic [255:0] a, input logic [255:0] b, input logic [255:0] exp);
    int lat;
    start_op(a, b);
    wait_result(lat);
    finish_op(tag, exp);
  endtask

  // Three widths run the same random traffic in parallel
  for (genvar g = 0; g < 3; g++) begin : g_rand
    localparam int unsigned W = (g == 0) ? 32 : ((g == 1) ? 64 : 256);
    mod_add_seq_if bus ();
    mod_add_seq #(.LIMB_W(W)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    bit done_flag = 1'b0;

    initial begin
      logic [255:0] a;
      logic [255:0] b;
      logic [255:0] exp;
      int           n;
      bit           got;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.A = 256'd0;
      bus.B = 256'd0;
      wait (rand_go);
      for (int k = 0; k < N_RAND; k++) begin
        a = rand_fe();
        b = rand_fe();
        exp = ref_add(a, b);
        bus.A = a;
        bus.B = b;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 100) begin
          @(negedge clk);
          n++;
        end
        check_val("rand_accept", {255'd0, bus.in_ready}, 256'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.A = ~a;
        got = 1'b0;
        n = 0;
        while (!got && n < 400) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          if (bus.out_valid && bus.out_ready) begin
            check_val("rand_add", bus.R, exp);
            check_val("rand_sub", mod_sub(bus.R, b), a);
            got = 1'b1;
          end
          @(negedge clk);
          n++;
        end
        bus.out_ready = 1'b0;
        if (!got) check_val("rand_timeout", {255'd0, bus.out_valid}, 256'd1);
      end
      done_flag = 1'b1;
    end
  end

  initial begin
    logic [255:0] half;
    int           lat;
    half = 256'd1 << 255;
    rst_n = 1'b0;
    bus_d.in_valid  = 1'b0;
    bus_d.out_ready = 1'b0;
    bus_d.A = 256'd0;
    bus_d.B = 256'd0;
    repeat (3) @(negedge clk);
    check_val("rst_in_ready", {255'd0, bus_d.in_ready}, 256'd1);
    check_val("rst_out_valid", {255'd0, bus_d.out_valid}, 256'd0);
    check_val("rst_busy", {255'd0, bus_d.busy}, 256'd0);
    check_val("rst_r", bus_d.R, 256'd0);
    rst_n = 1'b1;

    run_op("add_small", 256'd1, 256'd2, 256'd3);
    run_op("add_eq_p", P - 256'd1, 256'd1, 256'd0);
    run_op("add_wrap", P - 256'd1, P - 256'd1, P - 256'd2);
    run_op("add_half", half, half, 256'h1_000003D1);

    // Backpressure: result must hold while a stray in_valid is ignored
    start_op(256'd10, 256'd20);
    wait_result(lat);
    for (int k = 0; k < 10; k++) begin
      check_val("bp_valid", {255'd0, bus_d.out_valid}, 256'd1);
      check_val("bp_r", bus_d.R, 256'd30);
      check_val("bp_in_ready", {255'd0, bus_d.in_ready}, 256'd0);
      if (k == 2) begin
        bus_d.in_valid = 1'b1;
        bus_d.A = 256'd100;
        bus_d.B = 256'd200;
      end
      @(negedge clk);
    end
    bus_d.in_valid = 1'b0;
    bus_d.out_ready = 1'b1;
    @(negedge clk);
    check_val("bp_hs", {255'd0, bus_d.out_valid}, 256'd0);
    @(negedge clk);
    check_val("bp_one_hs", {255'd0, bus_d.out_valid}, 256'd0);
    check_val("bp_idle", {255'd0, bus_d.busy}, 256'd0);
    check_val("bp_r_kept", bus_d.R, 256'd30);
    bus_d.out_ready = 1'b0;

    // Reset during the second ADD cycle aborts the operation
    start_op(P - 256'd1, 256'd9);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("abort_in_ready", {255'd0, bus_d.in_ready}, 256'd1);
    check_val("abort_out_valid", {255'd0, bus_d.out_valid}, 256'd0);
    check_val("abort_r", bus_d.R, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check_val("abort_no_valid", {255'd0, bus_d.out_valid}, 256'd0);
    run_op("after_abort", 256'd5, 256'd7, 256'd12);

    @(negedge clk);
    rand_go = 1'b1;
    wait (g_rand[0].done_flag && g_rand[1].done_flag && g_rand[2].done_flag);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
